// File: rtl/k051962_layer_serializer.sv
// ============================================================================
// k051962_layer_serializer
// ----------------------------------------------------------------------------
// Tile-pixel serializer for one tile layer. This is the receiving end of the
// tile-fetch interface. For each 8-pixel tile it takes 32 bits of gfx ROM
// data (four bitplanes), an 8-bit color attribute and a flip-X flag. It then
// emits one 12-bit pixel {attr, color} on every pixel-clock enable.
//
// Everything runs on M24. The pixel rate is set by the PXCE enable.
//
// Build option:
//   K051962_FINE_SCROLL_EN  defined   -> 8-entry history of emitted pixels.
//                                        The output tap is picked by ZH, so
//                                        ZH adds 0..7 pixels of delay.
//   K051962_FINE_SCROLL_EN  undefined -> no history and ZH is ignored.
//                                        Latency is fixed at one pixel.
//
// Ports:
//   M24    in   1  master clock; every state change is on its rising edge
//   RES    in   1  synchronous active-high reset; wins over PXCE/TLOAD
//   PXCE   in   1  pixel clock enable, one M24 cycle wide
//   TLOAD  in   1  tile load strobe; only looked at when PXCE=1
//   ROMD   in  32  bitplanes: p3=[31:24] p2=[23:16] p1=[15:8] p0=[7:0]
//   COL    in   8  tile color attribute, captured together with ROMD
//   FLIPX  in   1  horizontal flip, captured together with ROMD
//   ZH     in   3  fine horizontal scroll {Z4H,Z2H,Z1H}, sampled every PXCE
//   NBLK   in   1  active-low blank; 0 forces a transparent output
//   PIX    out 12  {attr[7:0], color[3:0]}, registered
//   OPQ    out  1  1 when the PIX color is non-zero and not blanked
//   UNDR   out  1  sticky underrun flag; cleared only by RES
// ============================================================================
module k051962_layer_serializer #(
  parameter int HIST_DEPTH = 8
) (
  input  logic        M24,
  input  logic        RES,
  input  logic        PXCE,
  input  logic        TLOAD,
  input  logic [31:0] ROMD,
  input  logic [7:0]  COL,
  input  logic        FLIPX,
  input  logic [2:0]  ZH,
  input  logic        NBLK,
  output logic [11:0] PIX,
  output logic        OPQ,
  output logic        UNDR
);

  // A tile is exactly HIST_DEPTH (= 8) pixels wide. The in-tile pixel index
  // therefore has the same width as the history tap select.
  localparam int                IDX_W    = $clog2(HIST_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(HIST_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Shifter state for the current tile
  // --------------------------------------------------------------------------
  logic [31:0]      planes_reg;
  logic [7:0]       attr_reg;
  logic             flip_reg;
  logic [IDX_W-1:0] idx_reg,   idx_next;
  logic             valid_reg, valid_next;
  logic             undr_reg,  undr_next;

  // The source of the pixel emitted on this PXCE. On a load edge this is
  // the incoming ROM word itself, so pixel 0 of a new tile goes out on the
  // same edge that captures it.
  logic [31:0]      src_planes;
  logic [7:0]       src_attr;
  logic             src_flip;
  logic [IDX_W-1:0] src_idx;
  logic             src_ok;

  always_comb begin
    src_planes = planes_reg;
    src_attr   = attr_reg;
    src_flip   = flip_reg;
    src_idx    = idx_reg + 1'b1;
    src_ok     = 1'b0;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    undr_next  = undr_reg;

    if (TLOAD) begin
      // A load replaces the tile at once, even if the old tile is not
      // finished. An early load simply aborts the old tile.
      src_planes = ROMD;
      src_attr   = COL;
      src_flip   = FLIPX;
      src_idx    = '0;
      src_ok     = 1'b1;
      idx_next   = '0;
      valid_next = 1'b1;
    end else if (valid_reg && (idx_reg != IDX_LAST)) begin
      src_ok     = 1'b1;
      idx_next   = idx_reg + 1'b1;
    end else begin
      // Either no tile is held, or pixel 7 has already gone out and no new
      // tile arrived. A pixel is needed but none is available, so emit
      // transparent and latch the underrun.
      idx_next   = '0;
      valid_next = 1'b0;
      undr_next  = 1'b1;
    end
  end

  // Unflipped tiles emit the MSB of each plane first, so bit = 7 - idx. For a
  // power-of-two tile width that is simply the bitwise inverse of the index.
  logic [IDX_W-1:0] bit_sel;
  assign bit_sel = src_flip ? src_idx : ~src_idx;

  logic [7:0]  plane_w [4];
  logic [3:0]  color;
  logic [11:0] emit_pix;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_plane
      assign plane_w[gi] = src_planes[gi*8 +: 8];
      assign color[gi]   = plane_w[gi][bit_sel];
    end
  endgenerate

  assign emit_pix = src_ok ? {src_attr, color} : 12'h000;

  always_ff @(posedge M24) begin
    if (RES) begin
      planes_reg <= '0;
      attr_reg   <= '0;
      flip_reg   <= 1'b0;
      idx_reg    <= '0;
      valid_reg  <= 1'b0;
      undr_reg   <= 1'b0;
    end else if (PXCE) begin
      if (TLOAD) begin
        planes_reg <= ROMD;
        attr_reg   <= COL;
        flip_reg   <= FLIPX;
      end
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      undr_reg  <= undr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Fine-scroll history. tap is the pixel that the output register takes on
  // the next PXCE. hist_reg[0] holds the pixel emitted on the previous PXCE,
  // so ZH=0 adds no delay beyond the output register.
  // --------------------------------------------------------------------------
  logic [11:0] tap;

`ifdef K051962_FINE_SCROLL_EN
  logic [11:0] hist_reg [HIST_DEPTH];

  always_ff @(posedge M24) begin
    if (RES) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_reg[i] <= '0;
      end
    end else if (PXCE) begin
      hist_reg[0] <= emit_pix;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist_reg[i] <= hist_reg[i-1];
      end
    end
  end

  // ZH is sampled on the same PXCE edge that loads the output register.
  // A scroll change therefore repeats or drops pixels cleanly, with no
  // half-updated value in between.
  assign tap = hist_reg[ZH];
`else
  logic [11:0] hist0_reg;

  always_ff @(posedge M24) begin
    if (RES) begin
      hist0_reg <= '0;
    end else if (PXCE) begin
      hist0_reg <= emit_pix;
    end
  end

  assign tap = hist0_reg;

  logic unused_zh;
  assign unused_zh = ^ZH;
`endif

  // --------------------------------------------------------------------------
  // Output register. Blanking is applied only here, so the history and the
  // tile index keep advancing through a blank interval.
  // --------------------------------------------------------------------------
  logic [11:0] pix_reg;
  logic        opq_reg;

  always_ff @(posedge M24) begin
    if (RES) begin
      pix_reg <= '0;
      opq_reg <= 1'b0;
    end else if (PXCE) begin
      pix_reg <= NBLK ? tap : 12'h000;
      opq_reg <= NBLK && (tap[3:0] != 4'h0);
    end
  end

  assign PIX  = pix_reg;
  assign OPQ  = opq_reg;
  assign UNDR = undr_reg;

endmodule

// File: tb/tb_k051962_layer_serializer.sv
module tb_k051962_layer_serializer;

  logic        M24 = 1'b0;
  logic        RES;
  logic        PXCE;
  logic        TLOAD;
  logic [31:0] ROMD;
  logic [7:0]  COL;
  logic        FLIPX;
  logic [2:0]  ZH;
  logic        NBLK;
  logic [11:0] PIX;
  logic        OPQ;
  logic        UNDR;

  k051962_layer_serializer #(.HIST_DEPTH(8)) dut (
    .M24   (M24),
    .RES   (RES),
    .PXCE  (PXCE),
    .TLOAD (TLOAD),
    .ROMD  (ROMD),
    .COL   (COL),
    .FLIPX (FLIPX),
    .ZH    (ZH),
    .NBLK  (NBLK),
    .PIX   (PIX),
    .OPQ   (OPQ),
    .UNDR  (UNDR)
  );

  always #5 M24 = ~M24;

  // Extra delay that ZH=5 should add in this build.
`ifdef K051962_FINE_SCROLL_EN
  localparam int ZH5_LAT = 5;
`else
  localparam int ZH5_LAT = 0;
`endif

  typedef struct {
    int          edge_no;
    logic [11:0] pix;
    logic        opq;
    logic        undr;
    bit          chk_undr;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t keep_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   issued   = 0;   // PXCE edges issued by stimulus
  int   edge_cnt = 0;   // PXCE edges seen by the monitor

  task automatic compare(input string name, input logic [11:0] p, input logic o,
                         input logic u, input bit cu);
    n_cmp++;
    if (PIX !== p || OPQ !== o || (cu && UNDR !== u)) begin
      n_bad++;
      $display("FAIL %s: got PIX=%03h OPQ=%0b UNDR=%0b, want PIX=%03h OPQ=%0b UNDR=%0b(chk=%0b)",
               name, PIX, OPQ, UNDR, p, o, u, cu);
    end else begin
      $display("ok   %s: PIX=%03h OPQ=%0b UNDR=%0b", name, PIX, OPQ, UNDR);
    end
  endtask

  task automatic expect_px(input int e, input logic [11:0] p, input logic o,
                           input logic u, input bit cu, input string name);
    exp_t x;
    x.edge_no  = e;
    x.pix      = p;
    x.opq      = o;
    x.undr     = u;
    x.chk_undr = cu;
    x.name     = $sformatf("%s@e%0d", name, e);
    sb.push_back(x);
  endtask

  // Monitor: on every PXCE edge, check the expectations filed for that edge.
  initial begin
    forever begin
      @(posedge M24);
      if (PXCE === 1'b1 && RES === 1'b0) begin
        edge_cnt++;
        #1;
        keep_q = {};
        foreach (sb[i]) begin
          if (sb[i].edge_no == edge_cnt) begin
            compare(sb[i].name, sb[i].pix, sb[i].opq, sb[i].undr, sb[i].chk_undr);
          end else if (sb[i].edge_no < edge_cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: missed, now at edge %0d", sb[i].name, edge_cnt);
          end else begin
            keep_q.push_back(sb[i]);
          end
        end
        sb = keep_q;
      end
    end
  end

  // One PXCE pulse; the next pulse follows 4 M24 cycles later.
  task automatic step(input bit tl, input logic [31:0] rd, input logic [7:0] c,
                      input bit fx, input logic [2:0] z, input bit nb);
    @(negedge M24);
    TLOAD = tl; ROMD = rd; COL = c; FLIPX = fx; ZH = z; NBLK = nb; PXCE = 1'b1;
    issued++;
    @(negedge M24);
    PXCE = 1'b0; TLOAD = 1'b0;
    repeat (2) @(negedge M24);
  endtask

  // A tile: TLOAD on the first step, then plain steps. NBLK is low for the
  // steps bf..bt.
  task automatic tile(input logic [31:0] rd, input logic [7:0] c, input bit fx,
                      input logic [2:0] z, input int nsteps, input int bf, input int bt);
    for (int i = 0; i < nsteps; i++) begin
      step(i == 0, rd, c, fx, z, !(i >= bf && i <= bt));
    end
  endtask

  // Colors derived by hand from ROMD=FF00F00F: p3=FF p2=00 p1=F0 p0=0F.
  // Pixels 0-3 use bits 7..4 -> {1,0,1,0}=A; pixels 4-7 use bits 3..0 -> {1,0,0,1}=9.
  logic [3:0] basic_c [8] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'h9, 4'h9, 4'h9};
  logic [3:0] flip_c  [8] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'hA, 4'hA, 4'hA};

  initial begin
    int e;
    RES = 1'b1; PXCE = 1'b0; TLOAD = 1'b0; ROMD = '0; COL = '0;
    FLIPX = 1'b0; ZH = 3'd0; NBLK = 1'b1;
    repeat (3) @(negedge M24);
    RES = 1'b0;
    @(negedge M24);
    compare("reset_init", 12'h000, 1'b0, 1'b0, 1'b1);

    // Basic decode: two back-to-back tiles, no underrun.
    e = issued + 1;
    for (int t = 0; t < 2; t++)
      for (int p = 0; p < 8; p++)
        expect_px(e + 8*t + p + 1, {8'h5A, basic_c[p]}, 1'b1, 1'b0, 1'b1, "basic");
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 8, -1, -1);
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 8, -1, -1);

    // Flip.
    e = issued + 1;
    for (int p = 0; p < 8; p++)
      expect_px(e + p + 1, {8'h5A, flip_c[p]}, 1'b1, 1'b0, 1'b1, "flip");
    tile(32'hFF00F00F, 8'h5A, 1'b1, 3'd0, 8, -1, -1);

    // Blank for 4 PXCE mid-tile; the following pixels resume at the right index.
    e = issued + 1;
    for (int p = 0; p < 4; p++)
      expect_px(e + p + 1, 12'h000, 1'b0, 1'b0, 1'b1, "blank");
    for (int p = 4; p < 8; p++)
      expect_px(e + p + 1, {8'h5A, basic_c[p]}, 1'b1, 1'b0, 1'b1, "after_blank");
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 8, 1, 4);

    // Early load at IDX=3; the new tile's pixel 0 follows directly.
    // Then a TLOAD pulse without PXCE must be ignored.
    e = issued + 1;
    for (int p = 0; p < 4; p++)
      expect_px(e + p + 1, {8'h5A, basic_c[p]}, 1'b1, 1'b0, 1'b1, "pre_abort");
    expect_px(e + 5, 12'h338, 1'b1, 1'b0, 1'b1, "early_load_px0");
    for (int p = 1; p < 8; p++)
      expect_px(e + 5 + p, 12'h330, 1'b0, 1'b0, 1'b1, "early_load_px");
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 4, -1, -1);
    tile(32'h80000000, 8'h33, 1'b0, 3'd0, 4, -1, -1);
    @(negedge M24);
    TLOAD = 1'b1; ROMD = 32'hFFFFFFFF; COL = 8'hEE;
    @(negedge M24);
    TLOAD = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 32'hFFFFFFFF, 8'hEE, 1'b0, 3'd0, 1'b1);

    // Fine scroll: pixel 0 (color 1) delayed by ZH=5 when the history is built.
    e = issued + 1;
    expect_px(e + 1 + ZH5_LAT, 12'h5A1, 1'b1, 1'b0, 1'b1, "fine_scroll_px0");
    expect_px(e + 2 + ZH5_LAT, 12'h5A0, 1'b0, 1'b0, 1'b1, "fine_scroll_px1");
    tile(32'h00000080, 8'h5A, 1'b0, 3'd5, 8, -1, -1);

    // Underrun: a full tile at ZH=0, then the next TLOAD is omitted.
    e = issued + 1;
    for (int p = 0; p < 7; p++)
      expect_px(e + p + 1, {8'h5A, basic_c[p]}, 1'b1, 1'b0, 1'b1, "pre_underrun");
    expect_px(e + 8, {8'h5A, basic_c[7]}, 1'b1, 1'b0, 1'b0, "last_px");
    expect_px(e + 9, 12'h000, 1'b0, 1'b1, 1'b1, "underrun");
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 8, -1, -1);
    step(1'b0, 32'h0, 8'h00, 1'b0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Reset mid-tile: UNDR clears, then the first PXCE without TLOAD underruns.
    tile(32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 3, -1, -1);
    @(negedge M24);
    RES = 1'b1;
    repeat (3) @(negedge M24);
    RES = 1'b0;
    compare("reset_mid", 12'h000, 1'b0, 1'b0, 1'b1);
    expect_px(issued + 1, 12'h000, 1'b0, 1'b1, 1'b1, "post_reset_underrun");
    step(1'b0, 32'hFF00F00F, 8'h5A, 1'b0, 3'd0, 1'b1);

    repeat (8) @(negedge M24);
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked (edge count %0d)", sb[i].name, edge_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
